// File: rtl/audio_hit_detect.sv
// ============================================================================
// audio_hit_detect: stereo peak-envelope hit detector with hold-off/hysteresis
// Optional: define AUDIO_HIT_COUNT_EN to build the running hit counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_hit_detect #(
  parameter logic [23:0] THRESH      = 24'd1048576,
  parameter logic [15:0] HOLDOFF     = 16'd4800,
  parameter int          DECAY_SHIFT = 4
) (
  input  logic        clk,
  input  logic        enable,
  input  logic [23:0] sample_l,
  input  logic [23:0] sample_r,
  input  logic        sample_valid,
  output logic        hit,
  output logic [1:0]  hit_side,
  output logic [23:0] peak_level,
  output logic        busy,
  output logic [15:0] hit_count
);

  localparam logic [23:0] REARM_LVL = THRESH >> 1;
  localparam logic [15:0] HOLD_LOAD = (HOLDOFF == 16'd0) ? 16'd1 : HOLDOFF;

  typedef enum logic [1:0] {
    ST_ARM   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_REARM = 2'd2
  } state_t;

  // Full-scale negative has no positive twin, so it saturates.
  function automatic logic [23:0] mag(input logic [23:0] x);
    if (x == 24'h800000)
      return 24'h7FFFFF;
    else if (x[23])
      return -x;
    else
      return x;
  endfunction

  function automatic logic [23:0] env_next(input logic [23:0] a, input logic [23:0] e);
    logic [23:0] decayed;
    decayed = e - (e >> DECAY_SHIFT);
    return (a >= decayed) ? a : decayed;
  endfunction

  logic [23:0] abs_l, abs_r;
  logic [23:0] env_l, env_r;
  logic        v1, v2;
  state_t      state;
  logic [15:0] hold_cnt;
  logic        l_cross, r_cross;
  logic        fire;

  assign l_cross = (env_l >= THRESH);
  assign r_cross = (env_r >= THRESH);
  assign fire    = v2 && (state == ST_ARM) && (l_cross || r_cross);

  always_ff @(posedge clk) begin
    if (!enable) begin
      abs_l <= 24'd0;
      abs_r <= 24'd0;
      env_l <= 24'd0;
      env_r <= 24'd0;
      v1    <= 1'b0;
      v2    <= 1'b0;
    end else begin
      v1 <= sample_valid;
      v2 <= v1;
      if (sample_valid) begin
        abs_l <= mag(sample_l);
        abs_r <= mag(sample_r);
      end
      if (v1) begin
        env_l <= env_next(abs_l, env_l);
        env_r <= env_next(abs_r, env_r);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!enable) begin
      state      <= ST_ARM;
      hold_cnt   <= 16'd0;
      hit        <= 1'b0;
      hit_side   <= 2'b00;
      peak_level <= 24'd0;
      busy       <= 1'b0;
    end else begin
      hit <= 1'b0;
      if (v2) begin
        peak_level <= (env_l >= env_r) ? env_l : env_r;
        case (state)
          ST_ARM: begin
            if (l_cross || r_cross) begin
              hit      <= 1'b1;
              hit_side <= {r_cross, l_cross};
              busy     <= 1'b1;
              hold_cnt <= HOLD_LOAD;
              state    <= ST_HOLD;
            end
          end
          ST_HOLD: begin
            if (hold_cnt == 16'd1)
              state <= ST_REARM;
            hold_cnt <= hold_cnt - 16'd1;
          end
          ST_REARM: begin
            // Hysteresis: both channels must fall below half threshold.
            if ((env_l < REARM_LVL) && (env_r < REARM_LVL)) begin
              busy  <= 1'b0;
              state <= ST_ARM;
            end
          end
          default: begin
            busy  <= 1'b0;
            state <= ST_ARM;
          end
        endcase
      end
    end
  end

`ifdef AUDIO_HIT_COUNT_EN
  logic [15:0] count_q;

  always_ff @(posedge clk) begin
    if (!enable)
      count_q <= 16'd0;
    else if (fire)
      count_q <= count_q + 16'd1;
  end

  assign hit_count = count_q;
`else
  logic unused_fire;
  assign unused_fire = fire;
  assign hit_count   = 16'd0;
`endif

endmodule

`default_nettype wire
